wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback stage of the 5-stage RISC-V pipeline: the producer side of the decode stage's register-file write port.
- Accepts retiring instructions from the MEM stage and waits for load data through a valid handshake.
- Performs load byte/half extraction and sign extension, then drives the registered write port (RegWriteWB/writeRegAddr/WD3).
- Stalls upstream while a load is outstanding; counts retired instructions; flags load timeouts.

Parameters:
- LOAD_TIMEOUT, 16: max WAIT cycles before abandoning a load.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  MEM stage presents an instruction
- RegWrite_i  in  1  instruction writes rd
- WriteSrc_i  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate
- rd_i  in  5  destination register
- funct3_i  in  3  load width/sign
- ALUResult_i  in  32  ALU result / load address
- pcPlus4_i  in  32  link value
- ImmOp_i  in  32  immediate (lui)
- memRdata_i  in  32  aligned word from data memory
- memRvalid_i  in  1  memRdata_i valid this cycle
- stall_o  out  1  upstream must hold; valid_i not accepted
- RegWriteWB_o  out  1  register write enable (to decode stage)
- writeRegAddr_o  out  5  register write address
- WD3_o  out  32  register write data
- retire_o  out  1  one-cycle pulse per completed instruction
- instret_o  out  CNT_W  retired-instruction count
- err_o  out  1  sticky load-timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Reset mid-WAIT abandons the load with no write and no retire.
- States: IDLE, WAIT.
- stall_o = (state == WAIT), combinational.
- Accept: IDLE and valid_i. Capture rd, RegWrite, WriteSrc, funct3, ALUResult[1:0], and the source value.
- Non-load accepted in cycle T, outputs at T+1 for exactly one cycle:
  - RegWriteWB_o = RegWrite_i && rd_i != 0.
  - writeRegAddr_o = rd_i.
  - WD3_o = source selected by WriteSrc_i.
  - retire_o = 1.
- Load (WriteSrc 01) accepted in T:
  - T+1: state WAIT, RegWriteWB_o = 0, WAIT counter = 0.
  - memRvalid_i in IDLE, or in the accept cycle, is ignored.
- In WAIT, memRvalid_i high in cycle U:
  - U+1: state IDLE; write asserted with extracted data; retire_o = 1.
  - A new instruction may be accepted in U+1; its write occurs at U+2. No write-port conflict is possible.
- Load extraction (off = captured ALUResult[1:0]):
  - 000 lb: byte at off, sign-extended.
  - 100 lbu: byte at off, zero-extended.
  - 001 lh: half at off[1], sign-extended.
  - 101 lhu: half at off[1], zero-extended.
  - 010 lw and all other codes: full word, offset ignored.
- Timeout: WAIT counter increments each WAIT cycle without memRvalid_i. When it reaches LOAD_TIMEOUT-1 with no memRvalid_i:
  - next cycle: state IDLE, err_o = 1 (sticky until reset), no write, no retire.
  - memRvalid_i in the final WAIT cycle wins over timeout.
- rd = 0 with RegWrite = 1: RegWriteWB_o = 0, but the instruction still retires.
- instret_o increments on each retire_o and wraps at 2^CNT_W.
- Outputs are registered. WD3_o and writeRegAddr_o hold their last values when RegWriteWB_o = 0.

Decomposition:
- Package riscv_pkg holds:
  - WriteSrc enum: WS_ALU, WS_MEM, WS_PC4, WS_IMM.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - WB FSM state enum.
- One combinational sub-module, load_extract (word, offset, funct3 -> 32-bit result), is instantiated in wb_stage.

Test Plan:
- ALU op: valid_i with RegWrite = 1, WS_ALU, rd = 5, ALUResult = 0x0000_1234 → next cycle RegWriteWB_o = 1, addr 5, WD3 0x1234, retire_o pulse, instret_o = 1.
- lb with 2-cycle latency: funct3 000, off = 3, memRdata = 0x80FF_0000, memRvalid_i on the 2nd WAIT cycle → stall_o high for 2 cycles; then WD3 0xFFFF_FF80, write to rd.
- lhu/lh: memRdata = 0xBEEF_1234, off = 2 → lhu gives 0x0000_BEEF, lh gives 0xFFFF_BEEF; off = 0 lh gives 0x0000_1234.
- x0 and jal: RegWrite = 1, rd = 0 → RegWriteWB_o = 0, retire_o = 1. Then WS_PC4 with pcPlus4 = 0x104, rd = 1 → WD3 0x104.
- Timeout: LOAD_TIMEOUT = 4, load with memRvalid_i never asserted → err_o set after 4 WAIT cycles, no write, stall_o drops. A late memRvalid_i in IDLE has no effect.
- Reset during WAIT: assert rst_i on the 2nd WAIT cycle → next cycle stall_o = 0, all outputs 0, instret_o = 0. A following memRvalid_i is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: writeback source select, load funct3 codes,
// and the writeback-stage FSM state encoding.
package riscv_pkg;

    // Register write data source selected in writeback
    typedef enum logic [1:0] {
        WS_ALU = 2'b00,
        WS_MEM = 2'b01,
        WS_PC4 = 2'b10,
        WS_IMM = 2'b11
    } write_src_t;

    // Load width/sign encodings (funct3 of the load opcode)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Writeback FSM: IDLE accepts instructions, WAIT holds for load data
    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_extract.sv
// Load data extraction: picks byte/half/word out of an aligned memory word
// using the low address bits and sign- or zero-extends it to 32 bits.
module load_extract
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and half out of the word
    always_comb begin
        byte_sel = word[7:0];
        unique case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Extend according to load type; unknown codes fall back to a full word
    always_comb begin
        result = word;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0, half_sel};
            F3_LW:   result = word;
            default: result = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits on load data with a
// timeout, and drives the registered register-file write port.
module wb_stage
    import riscv_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic [1:0]        WriteSrc_i,
    input  logic [4:0]        rd_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [31:0]       pcPlus4_i,
    input  logic [31:0]       ImmOp_i,
    input  logic [31:0]       memRdata_i,
    input  logic              memRvalid_i,
    output logic              stall_o,
    output logic              RegWriteWB_o,
    output logic [4:0]        writeRegAddr_o,
    output logic [31:0]       WD3_o,
    output logic              retire_o,
    output logic [CNT_W-1:0]  instret_o,
    output logic              err_o
);

    localparam int unsigned TO_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(LOAD_TIMEOUT - 1);

    wb_state_t       state, state_next;
    logic [TO_W-1:0] wait_cnt;

    logic [4:0]  rd_q;
    logic        regwrite_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        accept;
    logic        is_load;
    logic        load_done;
    logic        load_timeout;
    logic        retire_now;
    logic        nonload_we;
    logic        load_we;
    logic [31:0] src_val;
    logic [31:0] load_data;

    assign stall_o = (state == WB_WAIT);

    load_extract u_load_extract (
        .word   (memRdata_i),
        .offset (off_q),
        .funct3 (funct3_q),
        .result (load_data)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        is_load      = (write_src_t'(WriteSrc_i) == WS_MEM);
        load_done    = 1'b0;
        load_timeout = 1'b0;
        unique case (state)
            WB_IDLE: begin
                accept = valid_i;
                if (valid_i && is_load) begin
                    state_next = WB_WAIT;
                end
            end
            WB_WAIT: begin
                // Data arriving in the last allowed cycle beats the timeout
                if (memRvalid_i) begin
                    load_done  = 1'b1;
                    state_next = WB_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    load_timeout = 1'b1;
                    state_next   = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // Source mux for non-load write data
    always_comb begin
        src_val = ALUResult_i;
        unique case (write_src_t'(WriteSrc_i))
            WS_ALU:  src_val = ALUResult_i;
            WS_MEM:  src_val = '0;
            WS_PC4:  src_val = pcPlus4_i;
            WS_IMM:  src_val = ImmOp_i;
            default: src_val = ALUResult_i;
        endcase
    end

    assign nonload_we = RegWrite_i && (rd_i != 5'd0);
    assign load_we    = regwrite_q && (rd_q != 5'd0);
    assign retire_now = (accept && !is_load) || load_done;

    // Capture load context at accept; count WAIT cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            wait_cnt   <= '0;
        end else begin
            if (accept) begin
                rd_q       <= rd_i;
                regwrite_q <= RegWrite_i;
                funct3_q   <= funct3_i;
                off_q      <= ALUResult_i[1:0];
                wait_cnt   <= '0;
            end else if (state == WB_WAIT && !memRvalid_i && wait_cnt != WAIT_LAST) begin
                wait_cnt <= wait_cnt + TO_W'(1);
            end
        end
    end

    // Registered write port, retire pulse, instret and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            RegWriteWB_o   <= 1'b0;
            writeRegAddr_o <= '0;
            WD3_o          <= '0;
            retire_o       <= 1'b0;
            instret_o      <= '0;
            err_o          <= 1'b0;
        end else begin
            RegWriteWB_o <= 1'b0;
            retire_o     <= retire_now;
            if (accept && !is_load) begin
                RegWriteWB_o <= nonload_we;
                if (nonload_we) begin
                    writeRegAddr_o <= rd_i;
                    WD3_o          <= src_val;
                end
            end else if (load_done) begin
                RegWriteWB_o <= load_we;
                if (load_we) begin
                    writeRegAddr_o <= rd_q;
                    WD3_o          <= load_data;
                end
            end
            if (retire_now) begin
                instret_o <= instret_o + CNT_W'(1);
            end
            if (load_timeout) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever retire_o is seen.
module tb_wb_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        RegWrite_i;
    logic [1:0]  WriteSrc_i;
    logic [4:0]  rd_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUResult_i;
    logic [31:0] pcPlus4_i;
    logic [31:0] ImmOp_i;
    logic [31:0] memRdata_i;
    logic        memRvalid_i;
    logic        stall_o;
    logic        RegWriteWB_o;
    logic [4:0]  writeRegAddr_o;
    logic [31:0] WD3_o;
    logic        retire_o;
    logic [31:0] instret_o;
    logic        err_o;

    wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .RegWrite_i     (RegWrite_i),
        .WriteSrc_i     (WriteSrc_i),
        .rd_i           (rd_i),
        .funct3_i       (funct3_i),
        .ALUResult_i    (ALUResult_i),
        .pcPlus4_i      (pcPlus4_i),
        .ImmOp_i        (ImmOp_i),
        .memRdata_i     (memRdata_i),
        .memRvalid_i    (memRvalid_i),
        .stall_o        (stall_o),
        .RegWriteWB_o   (RegWriteWB_o),
        .writeRegAddr_o (writeRegAddr_o),
        .WD3_o          (WD3_o),
        .retire_o       (retire_o),
        .instret_o      (instret_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd3;
        logic [31:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_wd3 = '0;
    logic [31:0] m_instret = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic rw, input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        e.we = rw && (rd != 5'd0);
        if (e.we) begin
            m_addr = rd;
            m_wd3  = wd;
        end
        m_instret = m_instret + 1;
        e.addr    = m_addr;
        e.wd3     = m_wd3;
        e.instret = m_instret;
        exp_q.push_back(e);
    endtask

    // Monitor: every retire must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst_i) begin
            if (retire_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", {31'h0, retire_o}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("we", {31'h0, RegWriteWB_o}, {31'h0, e.we});
                    check("addr", {27'h0, writeRegAddr_o}, {27'h0, e.addr});
                    check("wd3", WD3_o, e.wd3);
                    check("instret", instret_o, e.instret);
                end
            end else if (RegWriteWB_o) begin
                check("write_without_retire", {31'h0, RegWriteWB_o}, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 20 && stall_o; n++) step();
        check("idle_before_issue", {31'h0, stall_o}, 32'h0);
    endtask

    task automatic issue(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [31:0] exp_wd);
        wait_idle();
        valid_i     = 1'b1;
        RegWrite_i  = rw;
        WriteSrc_i  = src;
        rd_i        = rd;
        funct3_i    = 3'b000;
        ALUResult_i = alu;
        pcPlus4_i   = pc4;
        ImmOp_i     = imm;
        push_exp(rw, rd, exp_wd);
        step();
        valid_i = 1'b0;
    endtask

    // Load with data returned on WAIT cycle 'lat'; optional junk rvalid in accept cycle
    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                           input int lat, input logic [31:0] data, input logic [31:0] exp_wd,
                           input logic early);
        wait_idle();
        valid_i     = 1'b1;
        RegWrite_i  = 1'b1;
        WriteSrc_i  = WS_MEM;
        rd_i        = rd;
        funct3_i    = f3;
        ALUResult_i = 32'h0000_2000 | {30'h0, off};
        memRvalid_i = early;
        memRdata_i  = 32'hDEAD_BEEF;
        push_exp(1'b1, rd, exp_wd);
        step();
        valid_i     = 1'b0;
        memRvalid_i = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            check("stall_in_wait", {31'h0, stall_o}, 32'h1);
            if (i == lat) begin
                memRvalid_i = 1'b1;
                memRdata_i  = data;
            end
            step();
            memRvalid_i = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; RegWrite_i = 1'b0; WriteSrc_i = 2'b00; rd_i = '0;
        funct3_i = '0; ALUResult_i = '0; pcPlus4_i = '0; ImmOp_i = '0;
        memRdata_i = '0; memRvalid_i = 1'b0;
        step(); step();
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_we", {31'h0, RegWriteWB_o}, 32'h0);
        check("rst_wd3", WD3_o, 32'h0);
        check("rst_instret", instret_o, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        rst_i = 1'b0;

        issue(1'b1, WS_ALU, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234);
        do_load(5'd6, F3_LB, 2'd3, 2, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1);
        do_load(5'd7, F3_LHU, 2'd2, 1, 32'hBEEF_1234, 32'h0000_BEEF, 1'b0);
        do_load(5'd8, F3_LH, 2'd2, 1, 32'hBEEF_1234, 32'hFFFF_BEEF, 1'b0);
        do_load(5'd9, F3_LH, 2'd0, 1, 32'hBEEF_1234, 32'h0000_1234, 1'b0);
        do_load(5'd10, F3_LBU, 2'd2, 1, 32'h80FF_0000, 32'h0000_00FF, 1'b0);
        do_load(5'd11, F3_LW, 2'd1, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
        issue(1'b1, WS_ALU, 5'd0, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_0055);
        issue(1'b1, WS_PC4, 5'd1, 32'h0, 32'h0000_0104, 32'h0, 32'h0000_0104);
        issue(1'b1, WS_IMM, 5'd2, 32'h0, 32'h0, 32'hABCD_E000, 32'hABCD_E000);
        issue(1'b0, WS_ALU, 5'd3, 32'h0000_7777, 32'h0, 32'h0, 32'h0000_7777);
        // Data in the final allowed WAIT cycle, then a back-to-back ALU op
        do_load(5'd12, F3_LW, 2'd0, 4, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
        issue(1'b1, WS_ALU, 5'd13, 32'h0000_00AA, 32'h0, 32'h0, 32'h0000_00AA);
        step();
        check("err_after_last_cycle_data", {31'h0, err_o}, 32'h0);

        // Timeout: no data for 4 WAIT cycles
        wait_idle();
        valid_i = 1'b1; RegWrite_i = 1'b1; WriteSrc_i = WS_MEM; rd_i = 5'd14; funct3_i = F3_LW;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_timeout_wait", {31'h0, stall_o}, 32'h1);
            check("err_before_timeout", {31'h0, err_o}, 32'h0);
            step();
        end
        check("stall_after_timeout", {31'h0, stall_o}, 32'h0);
        check("err_after_timeout", {31'h0, err_o}, 32'h1);
        check("no_write_timeout", {31'h0, RegWriteWB_o}, 32'h0);
        memRvalid_i = 1'b1; memRdata_i = 32'h1111_1111;
        step();
        memRvalid_i = 1'b0;
        check("late_rvalid_stall", {31'h0, stall_o}, 32'h0);
        check("err_sticky", {31'h0, err_o}, 32'h1);
        check("instret_after_timeout", instret_o, m_instret);

        // Reset on the second WAIT cycle
        wait_idle();
        valid_i = 1'b1; RegWrite_i = 1'b1; WriteSrc_i = WS_MEM; rd_i = 5'd15; funct3_i = F3_LW;
        step();
        valid_i = 1'b0;
        step();
        check("stall_before_reset", {31'h0, stall_o}, 32'h1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        m_addr = '0; m_wd3 = '0; m_instret = '0;
        check("mid_rst_stall", {31'h0, stall_o}, 32'h0);
        check("mid_rst_we", {31'h0, RegWriteWB_o}, 32'h0);
        check("mid_rst_addr", {27'h0, writeRegAddr_o}, 32'h0);
        check("mid_rst_wd3", WD3_o, 32'h0);
        check("mid_rst_instret", instret_o, 32'h0);
        check("mid_rst_err", {31'h0, err_o}, 32'h0);
        memRvalid_i = 1'b1; memRdata_i = 32'h2222_2222;
        step();
        memRvalid_i = 1'b0;
        step();
        check("post_rst_rvalid_instret", instret_o, 32'h0);
        check("post_rst_rvalid_stall", {31'h0, stall_o}, 32'h0);

        step(); step();
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
